// File: rtl/multi_rate_divider.sv
// multi_rate_divider
//   NUM_CH independent programmable tick generators. Each channel is a
//   down-counter that emits a one-cycle tick strobe when it expires, then
//   either reloads (periodic) or stops (one-shot).
//
// Optional feature macro: RATE_DIV_ACCEL_EN
//   When defined, every tick of a periodic channel shortens its period by
//   ACCEL_STEP, never going below ACCEL_MIN.
//
// Ports
//   clk        in   system clock (rising edge)
//   rst        in   asynchronous reset, active-high
//   wr_en      in   period write strobe
//   wr_ch      in   [CH_W]    channel addressed by a write
//   wr_period  in   [WIDTH]   new period P (tick every P+1 cycles)
//   wr_oneshot in   mode written with the period (1 = one-shot)
//   start      in   [NUM_CH]  per-channel arm/restart pulse
//   stop       in   [NUM_CH]  per-channel halt pulse (wins over start)
//   pause      in   global freeze of all counters, level-sensitive
//   tick       out  [NUM_CH]  registered one-cycle strobe
//   busy       out  [NUM_CH]  channel is running
module multi_rate_divider #(
  parameter int NUM_CH     = 4,
  parameter int CH_W       = 2,
  parameter int WIDTH      = 32,
  parameter int ACCEL_STEP = 1,
  parameter int ACCEL_MIN  = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CH_W-1:0]   wr_ch,
  input  logic [WIDTH-1:0]  wr_period,
  input  logic              wr_oneshot,
  input  logic [NUM_CH-1:0] start,
  input  logic [NUM_CH-1:0] stop,
  input  logic              pause,
  output logic [NUM_CH-1:0] tick,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

`ifdef RATE_DIV_ACCEL_EN
  // One extra bit so ACCEL_MIN + ACCEL_STEP cannot wrap.
  localparam logic [WIDTH:0] ACC_STEP_X   = (WIDTH+1)'(ACCEL_STEP);
  localparam logic [WIDTH:0] ACC_MIN_X    = (WIDTH+1)'(ACCEL_MIN);
  localparam logic [WIDTH:0] ACC_THRESH_X = ACC_MIN_X + ACC_STEP_X;

  function automatic logic [WIDTH-1:0] accel_next(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] p_x;
    p_x = {1'b0, p};
    if (p_x >= ACC_THRESH_X) begin
      accel_next = WIDTH'(p_x - ACC_STEP_X);
    end else if (p_x > ACC_MIN_X) begin
      accel_next = WIDTH'(ACC_MIN_X);
    end else begin
      accel_next = p;
    end
  endfunction
`else
  // Acceleration parameters are only consumed when the feature is built in.
  logic unused_accel_cfg;
  assign unused_accel_cfg = ^{ACCEL_STEP, ACCEL_MIN};
`endif

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    state_t           state_q, state_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic [WIDTH-1:0] reload_val;
    logic             oneshot_q, oneshot_d;
    logic             tick_q, tick_d;
    logic             wr_hit;

    // Full-width compare: an out-of-range wr_ch never aliases onto a channel.
    assign wr_hit = wr_en && (wr_ch == CH_W'(gi));

`ifdef RATE_DIV_ACCEL_EN
    // With acceleration the reload already uses the shortened period.
    assign reload_val = accel_next(period_q);
`else
    assign reload_val = period_q;
`endif

    always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      period_d  = period_q;
      oneshot_d = oneshot_q;
      tick_d    = 1'b0;

      if (stop[gi]) begin
        state_d = ST_IDLE;
      end else if (start[gi]) begin
        state_d = ST_RUN;
        cnt_d   = period_q;
      end else if (state_q == ST_RUN && !pause) begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else begin
          tick_d = 1'b1;
          if (oneshot_q) begin
            state_d = ST_IDLE;
          end else begin
            cnt_d    = reload_val;
            period_d = reload_val;
          end
        end
      end

      // A write lands after any reload decision, so the reload above used
      // the old period and the written one applies from the next reload.
      if (wr_hit) begin
        period_d  = wr_period;
        oneshot_d = wr_oneshot;
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        period_q  <= '0;
        oneshot_q <= 1'b0;
        tick_q    <= 1'b0;
      end else begin
        state_q   <= state_d;
        cnt_q     <= cnt_d;
        period_q  <= period_d;
        oneshot_q <= oneshot_d;
        tick_q    <= tick_d;
      end
    end

    assign tick[gi] = tick_q;
    assign busy[gi] = (state_q == ST_RUN);
  end

endmodule
